// File: rtl/perceptron_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer, the image BRAM and the perceptron core.
// The master modport is the sequencer's view; slave is the surrounding system.
interface perceptron_layer_sequencer_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 14,
    parameter int IDX_W   = 4
);
    logic                start;
    logic                busy;
    logic                done;
    logic                img_rd_en;
    logic [ADDR_W-1:0]   img_rd_addr;
    logic [DATA_W-1:0]   img_rd_data;
    logic                neuron_start;
    logic [WADDR_W-1:0]  weight_base;
    logic [DATA_W-1:0]   x_tdata;
    logic                x_tvalid;
    logic                x_tready;
    logic                x_tlast;
    logic [DATA_W-1:0]   y_tdata;
    logic                y_tvalid;
    logic                y_tready;
    logic [IDX_W-1:0]    class_idx;
    logic [DATA_W-1:0]   class_score;

    modport master (
        input  start, img_rd_data, x_tready, y_tdata, y_tvalid,
        output busy, done, img_rd_en, img_rd_addr, neuron_start, weight_base,
               x_tdata, x_tvalid, x_tlast, y_tready, class_idx, class_score
    );

    modport slave (
        output start, img_rd_data, x_tready, y_tdata, y_tvalid,
        input  busy, done, img_rd_en, img_rd_addr, neuron_start, weight_base,
               x_tdata, x_tvalid, x_tlast, y_tready, class_idx, class_score
    );
endinterface

// File: rtl/perceptron_layer_sequencer.sv
// Runs one fully-connected layer on a shared perceptron: per neuron it launches the core,
// streams the image pixels from BRAM through a 2-entry skid buffer and tracks the argmax score.
module perceptron_layer_sequencer #(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 10,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int WADDR_W     = 14,
    parameter int IDX_W       = 4
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_areset,
    perceptron_layer_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        STREAM,
        WAIT_Y,
        DONE
    } state_t;

    localparam logic [ADDR_W:0]    LP_NUM_PIX  = (ADDR_W+1)'(NUM_INPUTS);
    localparam logic [ADDR_W:0]    LP_LAST_PIX = (ADDR_W+1)'(NUM_INPUTS - 1);
    localparam logic [IDX_W-1:0]   LP_LAST_N   = IDX_W'(NUM_NEURONS - 1);
    localparam logic [WADDR_W-1:0] LP_WSTEP    = WADDR_W'(NUM_INPUTS);

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_neuron_start;
    logic [IDX_W-1:0]    r_n;
    logic [WADDR_W-1:0]  r_wbase;
    logic [ADDR_W:0]     r_p;
    logic [ADDR_W:0]     r_beat;
    logic                r_inflight;
    logic [1:0]          r_cnt;
    logic [DATA_W-1:0]   r_buf [0:1];
    logic [DATA_W-1:0]   r_max_score;
    logic [IDX_W-1:0]    r_max_idx;
    logic [IDX_W-1:0]    r_class_idx;
    logic [DATA_W-1:0]   r_class_score;

    logic                w_pop;
    logic [2:0]          w_used;
    logic                w_issue;
    logic                w_last_beat;
    logic                w_better;
    logic [DATA_W-1:0]   w_best_score;
    logic [IDX_W-1:0]    w_best_idx;

    // Occupancy counts the slot freed by this cycle's pop, so a steady stream
    // keeps one entry buffered and one read in flight: 1 beat per cycle.
    assign w_pop       = (r_cnt != 2'd0) && bus.x_tready;
    assign w_used      = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = ((r_state == LAUNCH) || (r_state == STREAM))
                         && (r_p < LP_NUM_PIX) && (w_used < 3'd2);
    assign w_last_beat = w_pop && (r_beat == LP_LAST_PIX);

    assign w_better     = (r_n == '0) || ($signed(bus.y_tdata) > $signed(r_max_score));
    assign w_best_score = w_better ? bus.y_tdata : r_max_score;
    assign w_best_idx   = w_better ? r_n : r_max_idx;

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.img_rd_en    = w_issue;
    assign bus.img_rd_addr  = r_p[ADDR_W-1:0];
    assign bus.neuron_start = r_neuron_start;
    assign bus.weight_base  = r_wbase;
    assign bus.x_tdata      = r_buf[0];
    assign bus.x_tvalid     = (r_cnt != 2'd0);
    assign bus.x_tlast      = (r_cnt != 2'd0) && (r_beat == LP_LAST_PIX);
    assign bus.y_tready     = (r_state == WAIT_Y);
    assign bus.class_idx    = r_class_idx;
    assign bus.class_score  = r_class_score;

    // Skid buffer: entry 0 is the head presented on the x stream.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_inflight <= 1'b0;
            r_cnt      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= w_issue;
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_buf[0] <= bus.img_rd_data;
                    end else begin
                        r_buf[1] <= bus.img_rd_data;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf[0] <= r_buf[1];
                    r_cnt    <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_buf[0] <= bus.img_rd_data;
                    end else begin
                        r_buf[0] <= r_buf[1];
                        r_buf[1] <= bus.img_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_neuron_start <= 1'b0;
            r_n            <= '0;
            r_wbase        <= '0;
            r_p            <= '0;
            r_beat         <= '0;
            r_max_score    <= '0;
            r_max_idx      <= '0;
            r_class_idx    <= '0;
            r_class_score  <= '0;
        end else begin
            r_neuron_start <= 1'b0;
            r_done         <= 1'b0;
            if (w_issue) begin
                r_p <= r_p + 1'b1;
            end
            if (w_pop) begin
                r_beat <= r_beat + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state        <= LAUNCH;
                        r_busy         <= 1'b1;
                        r_neuron_start <= 1'b1;
                        r_n            <= '0;
                        r_wbase        <= '0;
                        r_p            <= '0;
                        r_beat         <= '0;
                    end
                end
                LAUNCH: begin
                    r_state <= STREAM;
                end
                STREAM: begin
                    if (w_last_beat) begin
                        r_state <= WAIT_Y;
                    end
                end
                WAIT_Y: begin
                    if (bus.y_tvalid) begin
                        r_max_score <= w_best_score;
                        r_max_idx   <= w_best_idx;
                        if (r_n == LP_LAST_N) begin
                            r_state       <= DONE;
                            r_done        <= 1'b1;
                            r_busy        <= 1'b0;
                            r_class_idx   <= w_best_idx;
                            r_class_score <= w_best_score;
                            r_n           <= '0;
                            r_wbase       <= '0;
                        end else begin
                            r_state        <= LAUNCH;
                            r_neuron_start <= 1'b1;
                            r_n            <= r_n + 1'b1;
                            r_wbase        <= r_wbase + LP_WSTEP;
                            r_p            <= '0;
                            r_beat         <= '0;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_layer_sequencer.sv
// Scoreboard bench: BRAM and perceptron models around the sequencer, expected beats,
// weight bases and classifications queued at stimulus time and popped as the DUT produces them.
module tb_perceptron_layer_sequencer;
    localparam int NI = 4;
    localparam int NN = 3;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int WW = 14;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    perceptron_layer_sequencer_if #(.DATA_W(DW), .ADDR_W(AW), .WADDR_W(WW), .IDX_W(IW)) bus();

    perceptron_layer_sequencer #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_W(DW),
        .ADDR_W(AW), .WADDR_W(WW), .IDX_W(IW)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .bus          (bus)
    );

    int errors = 0;
    int checks = 0;

    int exp_pix_q[$];
    bit exp_last_q[$];
    int exp_wb_q[$];
    int exp_idx_q[$];
    int exp_score_q[$];
    int score_q[$];

    int pending_y = 0;
    int ns_cnt = 0;
    int done_cnt = 0;
    int beat_in_neuron = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit y_hs = 1'b0;
    bit tog_mode = 1'b0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Image BRAM: one cycle read latency
    always @(posedge clk) begin
        if (bus.img_rd_en) bus.img_rd_data <= mem[bus.img_rd_addr];
    end

    // Stream sink / perceptron model: x_tready pattern and score return
    initial begin
        bus.x_tready = 1'b0;
        bus.y_tvalid = 1'b0;
        bus.y_tdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.x_tready = tog_mode ? ~bus.x_tready : 1'b1;
            if (rst) begin
                bus.y_tvalid = 1'b0;
            end else if (y_hs) begin
                bus.y_tvalid = 1'b0;
                y_hs = 1'b0;
            end else if (!bus.y_tvalid && pending_y > 0 && score_q.size() > 0) begin
                bus.y_tdata  = score_q.pop_front();
                bus.y_tvalid = 1'b1;
                pending_y--;
            end
        end
    end

    // Monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            y_hs = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", bus.x_tvalid, 1);
                check_eq("stall_data", bus.x_tdata, prev_data);
            end
            if (bus.x_tvalid) check_eq("y_tready_in_stream", bus.y_tready, 0);
            if (bus.x_tvalid && bus.x_tready) begin
                if (exp_pix_q.size() == 0) begin
                    check_eq("beats_expected", exp_pix_q.size(), 1);
                end else begin
                    check_eq("beat_data", bus.x_tdata, exp_pix_q.pop_front());
                    check_eq("beat_last", bus.x_tlast, exp_last_q.pop_front());
                end
                beat_in_neuron++;
                if (beat_in_neuron == NI) pending_y++;
            end
            prev_stall = bus.x_tvalid && !bus.x_tready;
            prev_data  = bus.x_tdata;
            if (bus.neuron_start) begin
                ns_cnt++;
                beat_in_neuron = 0;
                if (exp_wb_q.size() == 0) check_eq("starts_expected", exp_wb_q.size(), 1);
                else check_eq("weight_base", bus.weight_base, exp_wb_q.pop_front());
            end
            if (bus.done) begin
                done_cnt++;
                check_eq("busy_at_done", bus.busy, 0);
                if (exp_idx_q.size() == 0) begin
                    check_eq("dones_expected", exp_idx_q.size(), 1);
                end else begin
                    check_eq("class_idx", bus.class_idx, exp_idx_q.pop_front());
                    check_eq("class_score", longint'($signed(bus.class_score)), exp_score_q.pop_front());
                end
            end
            y_hs = bus.y_tvalid && bus.y_tready;
        end
    end

    task automatic launch_case(input int s[NN], input bit tog, output int bi, output int bs);
        bi = 0;
        bs = s[0];
        tog_mode = tog;
        for (int n = 0; n < NN; n++) begin
            exp_wb_q.push_back(n * NI);
            for (int i = 0; i < NI; i++) begin
                exp_pix_q.push_back(i + 1);
                exp_last_q.push_back(i == NI - 1);
            end
            score_q.push_back(s[n]);
            if (n > 0 && s[n] > bs) begin
                bs = s[n];
                bi = n;
            end
        end
        exp_idx_q.push_back(bi);
        exp_score_q.push_back(bs);
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        check_eq("busy_after_start", bus.busy, 1);
    endtask

    task automatic run_case(input int s[NN], input bit tog, input bit extra_start);
        int d0;
        int n0;
        int bi;
        int bs;
        int cyc;
        d0 = done_cnt;
        n0 = ns_cnt;
        launch_case(s, tog, bi, bs);
        cyc = 0;
        while (done_cnt == d0 && cyc < 300) begin
            @(posedge clk); #1;
            bus.start = (extra_start && cyc == 5);
            cyc++;
        end
        bus.start = 1'b0;
        check_eq("done_seen", done_cnt, d0 + 1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("done_once", done_cnt, d0 + 1);
        check_eq("neuron_starts", ns_cnt - n0, NN);
        check_eq("beats_left", exp_pix_q.size(), 0);
        check_eq("class_idx_hold", bus.class_idx, bi);
        check_eq("class_score_hold", longint'($signed(bus.class_score)), bs);
        check_eq("idle_busy", bus.busy, 0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_busy"}, bus.busy, 0);
        check_eq({pfx, "_done"}, bus.done, 0);
        check_eq({pfx, "_img_rd_en"}, bus.img_rd_en, 0);
        check_eq({pfx, "_img_rd_addr"}, bus.img_rd_addr, 0);
        check_eq({pfx, "_neuron_start"}, bus.neuron_start, 0);
        check_eq({pfx, "_weight_base"}, bus.weight_base, 0);
        check_eq({pfx, "_x_tvalid"}, bus.x_tvalid, 0);
        check_eq({pfx, "_x_tdata"}, bus.x_tdata, 0);
        check_eq({pfx, "_x_tlast"}, bus.x_tlast, 0);
        check_eq({pfx, "_y_tready"}, bus.y_tready, 0);
        check_eq({pfx, "_class_idx"}, bus.class_idx, 0);
        check_eq({pfx, "_class_score"}, bus.class_score, 0);
    endtask

    initial begin
        int bi;
        int bs;
        int n0;
        int cyc;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 1);
        bus.start = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        run_case('{5, -2, 9}, 1'b0, 1'b0);
        run_case('{4, 6, 1}, 1'b1, 1'b1);
        run_case('{7, 7, -1}, 1'b0, 1'b0);
        run_case('{-10, -3, -8}, 1'b1, 1'b0);

        // Abort in the middle of neuron 1's stream, then classify again
        n0 = ns_cnt;
        launch_case('{1, 2, 3}, 1'b0, bi, bs);
        cyc = 0;
        while (!(ns_cnt - n0 == 2 && beat_in_neuron >= 2) && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        check_eq("reached_neuron1", ns_cnt - n0, 2);
        #3 rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        exp_pix_q.delete();
        exp_last_q.delete();
        exp_wb_q.delete();
        exp_idx_q.delete();
        exp_score_q.delete();
        score_q.delete();
        pending_y = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_case('{1, 2, 3}, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/perceptron_layer_sequencer.md
Name: perceptron_layer_sequencer

Overview:
- Controller that runs one fully-connected layer on the single shared perceptron datapath.
- For each of NUM_NEURONS neurons it:
  - pulses the perceptron start;
  - publishes that neuron's weight base address;
  - streams the NUM_INPUTS image pixels from image BRAM onto the perceptron's x AXI-stream;
  - collects the neuron's signed score.
- It keeps a running argmax and reports the classified digit with a done pulse.
- Sits between the image BRAM/loader and the perceptron core.

Parameters:
- NUM_INPUTS, 784, pixels per image (must be ≥ 2)
- NUM_NEURONS, 10, neurons (classes) per layer (must be ≥ 1)
- DATA_W, 32, pixel and score width
- ADDR_W, 10, image BRAM address width
- WADDR_W, 14, weight base address width
- IDX_W, 4, class index width

Ports:
- s_axi_aclk  in  1  clock
- s_axi_areset  in  1  asynchronous reset, active-high
- start  in  1  one-cycle request to classify the image currently in BRAM
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse; class outputs valid from this cycle
- img_rd_en  out  1  image BRAM read enable
- img_rd_addr  out  ADDR_W  image BRAM address
- img_rd_data  in  DATA_W  BRAM data, valid exactly 1 cycle after img_rd_en
- neuron_start  out  1  one-cycle start pulse to perceptron
- weight_base  out  WADDR_W  neuron index × NUM_INPUTS; stable while busy for the current neuron
- x_tdata  out  DATA_W  pixel stream data
- x_tvalid  out  1  pixel stream valid
- x_tready  in  1  pixel stream ready
- x_tlast  out  1  high with pixel NUM_INPUTS-1
- y_tdata  in  DATA_W  signed neuron score
- y_tvalid  in  1  score valid
- y_tready  out  1  score ready
- class_idx  out  IDX_W  argmax neuron index
- class_score  out  DATA_W  score of argmax neuron

Behaviour:
- Reset (async, any state, including mid-stream):
  - state IDLE;
  - all outputs 0, including class_idx, class_score and weight_base;
  - pixel buffer emptied; in-flight reads discarded.
- States: IDLE, LAUNCH, STREAM, WAIT_Y, DONE.
- IDLE:
  - start=1 → LAUNCH; busy=1 from the next cycle;
  - neuron counter n=0; weight_base=0.
- start while busy is ignored.
- LAUNCH:
  - neuron_start=1 for exactly this cycle;
  - pixel counter p=0;
  - next state STREAM.
- STREAM, read issue:
  - img_rd_addr=p;
  - img_rd_en=1 when p<NUM_INPUTS and (buffer occupancy + reads in flight) < 2; p increments on each issue.
- STREAM, return data: enters a 2-entry skid buffer whose head drives x_tdata/x_tvalid.
- STREAM, handshake:
  - a beat transfers on x_tvalid & x_tready;
  - x_tvalid, once high, holds x_tdata stable until accepted (AXI-stream rules);
  - x_tlast marks beat index NUM_INPUTS-1.
- Throughput: with x_tready held high, first beat appears 2 cycles after LAUNCH, then 1 beat/cycle.
- Transfer of the last beat → WAIT_Y.
- WAIT_Y:
  - y_tready=1;
  - on y_tvalid the score is compared as signed.
- Argmax rules:
  - n=0 → loads unconditionally;
  - n>0 → replaces only if strictly greater (ties keep lower index).
- After a score is taken in WAIT_Y:
  - if n=NUM_NEURONS-1 → DONE;
  - else n+1, weight_base += NUM_INPUTS, → LAUNCH.
- y_tvalid outside WAIT_Y is not accepted (y_tready=0).
- DONE: done=1 for one cycle; busy=0 at the same edge; → IDLE.
- class_idx/class_score hold until the next done or reset. They are not cleared at start; internal running max is separate.
- Perceptron only sees NUM_INPUTS beats per neuron_start.

Test Plan (NUM_INPUTS=4, NUM_NEURONS=3, BRAM[i]=i+1):
- Reset → all outputs 0, busy=0.
- Start, x_tready=1, perceptron returns scores 5, -2, 9 → see the following:
  - neuron_start pulses 3 times;
  - weight_base 0, 4, 8;
  - beats 1,2,3,4 per neuron, x_tlast on beat 4;
  - done once; class_idx=2, class_score=9.
- x_tready toggling 1/0 every cycle → beats 1..4 in order, no drop/duplicate, x_tdata stable while stalled.
- Scores 7, 7, -1 → class_idx=0, class_score=7 (tie keeps lower index).
- Scores -10, -3, -8 → class_idx=1, class_score=-3.
- Assert reset mid-STREAM of neuron 1, then start again with scores 1, 2, 3 → first beat after restart is 1; weight_base restarts at 0; class_idx=2.
